// File: rtl/rom_fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads a 3-word ROM window and emits
// one variable-length command per cycle over valid/ready, with redirect, halt and fault handling.
module rom_fetch_sequencer #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter int                      WORD_SIZE    = 32,
    parameter int                      N_WORDS      = 128,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDR   = '0,
    parameter logic [7:0]              HALT_OPCODE  = 8'hFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [ADDRESS_SIZE-1:0]   rom_address,
    input  logic [3*WORD_SIZE-1:0]    rom_data,
    input  logic                      redirect_valid,
    input  logic [ADDRESS_SIZE-1:0]   redirect_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3*WORD_SIZE-1:0]    out_instr,
    output logic [1:0]                out_len,
    output logic [ADDRESS_SIZE-1:0]   out_pc,
    output logic                      halted,
    output logic                      fault
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_FAULT} state_t;

    localparam logic [ADDRESS_SIZE:0] NW_LIM = (ADDRESS_SIZE+1)'(N_WORDS);

    state_t                    state_p0, state_nxt;
    logic [ADDRESS_SIZE-1:0]   pc_p0, pc_nxt;
    logic                      vld_p1, vld_nxt;
    logic [3*WORD_SIZE-1:0]    instr_p1, instr_nxt;
    logic [1:0]                len_p1, len_nxt;
    logic [ADDRESS_SIZE-1:0]   cmd_pc_p1, cmd_pc_nxt;

    logic [1:0]                len_field;
    logic [7:0]                opcode;
    logic [ADDRESS_SIZE:0]     end_addr;
    logic                      cmd_ok;
    logic                      slot_free;

    // Keep only the words belonging to the command; the rest read as zero.
    function automatic logic [3*WORD_SIZE-1:0] mask_window(
        input logic [3*WORD_SIZE-1:0] win,
        input logic [1:0]             len
    );
        case (len)
            2'd1:    return {{(2*WORD_SIZE){1'b0}}, win[WORD_SIZE-1:0]};
            2'd2:    return {{WORD_SIZE{1'b0}}, win[2*WORD_SIZE-1:0]};
            default: return win;
        endcase
    endfunction

    assign len_field = rom_data[WORD_SIZE-1:WORD_SIZE-2];
    assign opcode    = rom_data[7:0];
    // Extra sum bit means a PC near the top of the address space can never wrap into range.
    assign end_addr  = {1'b0, pc_p0} + (ADDRESS_SIZE+1)'(len_field);
    assign cmd_ok    = (len_field != 2'b00) && (end_addr <= NW_LIM);
    assign slot_free = !vld_p1 || out_ready;

    always_comb begin
        state_nxt  = state_p0;
        pc_nxt     = pc_p0;
        vld_nxt    = vld_p1;
        instr_nxt  = instr_p1;
        len_nxt    = len_p1;
        cmd_pc_nxt = cmd_pc_p1;
        case (state_p0)
            S_IDLE: begin
                if (redirect_valid) pc_nxt = redirect_addr;
                if (start)          state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_nxt  = redirect_addr;
                    vld_nxt = 1'b0;
                end else if (slot_free) begin
                    if (!cmd_ok) begin
                        state_nxt = S_FAULT;
                        vld_nxt   = 1'b0;
                    end else begin
                        instr_nxt  = mask_window(rom_data, len_field);
                        len_nxt    = len_field;
                        cmd_pc_nxt = pc_p0;
                        vld_nxt    = 1'b1;
                        pc_nxt     = pc_p0 + ADDRESS_SIZE'(len_field);
                        if (opcode == HALT_OPCODE) state_nxt = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_addr;
                    vld_nxt   = 1'b0;
                    state_nxt = S_FETCH;
                end else if (out_ready) begin
                    vld_nxt = 1'b0;
                end
            end
            S_FAULT: vld_nxt = 1'b0;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 holds control (state, PC); stage p1 is the command handed to decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0  <= S_IDLE;
            pc_p0     <= START_ADDR;
            vld_p1    <= 1'b0;
            instr_p1  <= '0;
            len_p1    <= '0;
            cmd_pc_p1 <= '0;
        end else begin
            state_p0  <= state_nxt;
            pc_p0     <= pc_nxt;
            vld_p1    <= vld_nxt;
            instr_p1  <= instr_nxt;
            len_p1    <= len_nxt;
            cmd_pc_p1 <= cmd_pc_nxt;
        end
    end

    assign rom_address = pc_p0;
    assign out_valid   = vld_p1;
    assign out_instr   = instr_p1;
    assign out_len     = len_p1;
    assign out_pc      = cmd_pc_p1;
    assign halted      = (state_p0 == S_HALT);
    assign fault       = (state_p0 == S_FAULT);

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer: behavioural ROM array plus hand-derived
// expectations for fetch, backpressure, redirect, halt, fault and reset.
module tb_rom_fetch_sequencer;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int NW = 128;

    logic              clk = 1'b0;
    logic              rst_n, start, redirect_valid, out_ready;
    logic [AW-1:0]     rom_address, redirect_addr, out_pc;
    logic [3*WW-1:0]   rom_data, out_instr;
    logic              out_valid, halted, fault;
    logic [1:0]        out_len;
    logic [WW-1:0]     rom [0:NW-1];
    logic [AW:0]       a0, a1, a2;
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    rom_fetch_sequencer #(
        .ADDRESS_SIZE(AW), .WORD_SIZE(WW), .N_WORDS(NW),
        .START_ADDR('0), .HALT_OPCODE(8'hFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_address(rom_address), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_len(out_len), .out_pc(out_pc),
        .halted(halted), .fault(fault)
    );

    // Combinational ROM window; addresses past the end read as zero.
    assign a0 = {1'b0, rom_address};
    assign a1 = a0 + 33'd1;
    assign a2 = a0 + 33'd2;
    assign rom_data = {(a2 < NW) ? rom[a2[6:0]] : 32'h0,
                       (a1 < NW) ? rom[a1[6:0]] : 32'h0,
                       (a0 < NW) ? rom[a0[6:0]] : 32'h0};

    function automatic logic [WW-1:0] mkw(input logic [1:0] lf, input logic [7:0] op,
                                          input logic [21:0] tag);
        return {lf, tag, op};
    endfunction

    task automatic chk(input string tag, input logic [3*WW-1:0] obs, input logic [3*WW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill();
        for (int i = 0; i < NW; i++) rom[i] = mkw(2'b01, 8'h01, 22'(i));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b1;
        fill();
        rom[1] = mkw(2'b11, 8'h22, 22'd1);
        rom[2] = 32'hA2A2_0002;
        rom[3] = 32'hA3A3_0003;
        rom[4] = mkw(2'b10, 8'h33, 22'd4);
        rom[5] = 32'hB5B5_0005;
        tick(); tick();

        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_len",   out_len,   0);
        chk("rst_pc",    out_pc,    0);
        chk("rst_halt",  halted,    0);
        chk("rst_fault", fault,     0);
        chk("rst_addr",  rom_address, 0);

        // Sequential fetch: len1@0, len3@1, len2@4
        rst_n = 1'b1;
        tick();
        chk("idle_valid", out_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_lat_valid", out_valid, 0);
        tick();
        chk("seq0_valid", out_valid, 1);
        chk("seq0_pc",    out_pc,    0);
        chk("seq0_len",   out_len,   1);
        chk("seq0_instr", out_instr, {64'h0, rom[0]});
        tick();
        chk("seq1_pc",    out_pc,    1);
        chk("seq1_len",   out_len,   3);
        chk("seq1_instr", out_instr, {rom[3], rom[2], rom[1]});
        tick();
        chk("seq2_pc",    out_pc,    4);
        chk("seq2_len",   out_len,   2);
        chk("seq2_instr", out_instr, {32'h0, rom[5], rom[4]});
        chk("seq2_addr",  rom_address, 6);

        // Mid-stream reset
        rst_n = 1'b0;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_instr", out_instr, 0);
        chk("mrst_len",   out_len,   0);
        chk("mrst_pc",    out_pc,    0);
        chk("mrst_addr",  rom_address, 0);
        chk("mrst_halt",  halted,    0);
        rst_n = 1'b1;
        fill();
        tick();
        chk("mrst_idle0", out_valid, 0);
        tick();
        chk("mrst_idle1", out_valid, 0);

        // Backpressure after the first command
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("bp_first_pc", out_pc, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_pc",    out_pc,    0);
            chk("bp_hold_addr",  rom_address, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_pc",    out_pc,    1);

        // Redirect drops a pending command
        do_reset();
        fill();
        redirect_valid = 1'b1; redirect_addr = 5;
        tick();
        redirect_valid = 1'b0;
        chk("idle_redir_addr", rom_address, 5);
        start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("rd_pend_valid", out_valid, 1);
        chk("rd_pend_pc",    out_pc,    5);
        redirect_valid = 1'b1; redirect_addr = 20;
        tick();
        redirect_valid = 1'b0;
        chk("rd_bubble_valid", out_valid, 0);
        chk("rd_bubble_addr",  rom_address, 20);
        out_ready = 1'b1;
        tick();
        chk("rd_tgt_valid", out_valid, 1);
        chk("rd_tgt_pc",    out_pc,    20);

        // Halt at address 3, then resume via redirect
        do_reset();
        fill();
        rom[3] = mkw(2'b01, 8'hFF, 22'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("h_pre_pc",   out_pc, 2);
        chk("h_pre_halt", halted, 0);
        tick();
        chk("h_cmd_valid", out_valid, 1);
        chk("h_cmd_pc",    out_pc,    3);
        chk("h_cmd_halt",  halted,    1);
        tick();
        chk("h_drop_valid", out_valid, 0);
        chk("h_drop_halt",  halted,    1);
        tick();
        chk("h_idle_valid", out_valid, 0);
        redirect_valid = 1'b1; redirect_addr = 0;
        tick();
        redirect_valid = 1'b0;
        chk("h_resume_halt",  halted,    0);
        chk("h_resume_valid", out_valid, 0);
        tick();
        chk("h_resume_cmd_valid", out_valid, 1);
        chk("h_resume_cmd_pc",    out_pc,    0);

        // Illegal length field at address 2
        do_reset();
        fill();
        rom[2] = mkw(2'b00, 8'h05, 22'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("f_pre_pc", out_pc, 1);
        tick();
        chk("f_ill_fault", fault,     1);
        chk("f_ill_valid", out_valid, 0);
        start = 1'b1; redirect_valid = 1'b1; redirect_addr = 0;
        tick(); tick();
        start = 1'b0; redirect_valid = 1'b0;
        chk("f_sticky_fault", fault,     1);
        chk("f_sticky_valid", out_valid, 0);
        chk("f_sticky_halt",  halted,    0);

        // len2 at 126 ends exactly at N_WORDS: legal
        do_reset();
        fill();
        rom[126] = mkw(2'b10, 8'h06, 22'd126);
        redirect_valid = 1'b1; redirect_addr = 126;
        tick();
        redirect_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("b2_valid", out_valid, 1);
        chk("b2_pc",    out_pc,    126);
        chk("b2_len",   out_len,   2);
        chk("b2_fault", fault,     0);

        // len3 at 126 overruns: fault
        do_reset();
        fill();
        rom[126] = mkw(2'b11, 8'h07, 22'd126);
        redirect_valid = 1'b1; redirect_addr = 126;
        tick();
        redirect_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("b3_fault", fault,     1);
        chk("b3_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
